aes_state_buf: RTL

//  Clocked, parametrised AES state matrix (DIM x DIM cells of BYTE_W bits) with row/column

---
 rtl/aes_state_buf_pkg.sv | 52 +++++
 rtl/aes_state_buf_if.sv | 34 +++
 rtl/aes_state_buf_row_rot.sv | 37 +++
 rtl/aes_state_buf.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/aes_state_buf_pkg.sv
// Shared types for the AES state buffer: opcodes, default geometry and
// row/column packing helpers for the default 4x4 byte matrix.
package aes_state_pkg;

    localparam int unsigned DIM_DEF    = 4;
    localparam int unsigned BYTE_W_DEF = 8;
    localparam int unsigned W_DEF      = DIM_DEF * BYTE_W_DEF;
    localparam int unsigned IDX_W_DEF  = $clog2(DIM_DEF);

    typedef enum logic [2:0] {
        OpWrCol        = 3'd0,
        OpWrRow        = 3'd1,
        OpRdCol        = 3'd2,
        OpRdRow        = 3'd3,
        OpShiftRows    = 3'd4,
        OpInvShiftRows = 3'd5,
        OpClear        = 3'd6,
        OpTranspose    = 3'd7
    } op_e;

    typedef logic [BYTE_W_DEF-1:0] cell_t;
    typedef logic [W_DEF-1:0]      word_t;
    typedef logic [IDX_W_DEF-1:0]  idx_t;
    // mat[r][c]
    typedef cell_t [DIM_DEF-1:0][DIM_DEF-1:0] mat_t;

    // Row r packed with column 0 in the MSB cell.
    function automatic word_t row_word(mat_t m, idx_t r);
        word_t w;
        w = '0;
        for (int c = 0; c < DIM_DEF; c++) begin
            w[W_DEF-1-c*BYTE_W_DEF -: BYTE_W_DEF] = m[r][c];
        end
        return w;
    endfunction

    // Column c packed with row 0 in the MSB cell.
    function automatic word_t col_word(mat_t m, idx_t c);
        word_t w;
        w = '0;
        for (int r = 0; r < DIM_DEF; r++) begin
            w[W_DEF-1-r*BYTE_W_DEF -: BYTE_W_DEF] = m[r][c];
        end
        return w;
    endfunction

    // Cell i of a packed word, index 0 being the MSB cell.
    function automatic cell_t word_cell(word_t w, idx_t i);
        return cell_t'(w >> (BYTE_W_DEF * (DIM_DEF - 1 - int'(i))));
    endfunction

endpackage

// File: rtl/aes_state_buf_if.sv
// Command/response port of the AES state buffer. The master issues commands
// and consumes responses; the slave is the buffer itself.
interface aes_state_buf_if
    import aes_state_pkg::*;
#(
    parameter int unsigned DIM    = DIM_DEF,
    parameter int unsigned BYTE_W = BYTE_W_DEF
);

    localparam int unsigned W     = DIM * BYTE_W;
    localparam int unsigned IDX_W = $clog2(DIM);

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [W-1:0]     cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             busy;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, busy, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, busy, cmd_err
    );

endinterface

// File: rtl/aes_state_buf_row_rot.sv
// Combinational cell rotator for one DIM-cell row (cell 0 in the MSB).
// dir = 0 rotates left by amt cells, dir = 1 rotates right by amt cells.
module aes_row_rot
    import aes_state_pkg::*;
#(
    parameter int unsigned DIM    = DIM_DEF,
    parameter int unsigned BYTE_W = BYTE_W_DEF
) (
    input  logic [DIM*BYTE_W-1:0]  row,
    input  logic [$clog2(DIM)-1:0] amt,
    input  logic                   dir,
    output logic [DIM*BYTE_W-1:0]  rotated
);

    localparam int unsigned W     = DIM * BYTE_W;
    localparam int unsigned IDX_W = $clog2(DIM);

    logic [BYTE_W-1:0] cells [DIM];
    logic [IDX_W-1:0]  src   [DIM];

    // Split the packed row into cells.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            cells[i] = row[W-1-i*BYTE_W -: BYTE_W];
        end
    end

    // Source index wraps in IDX_W bits, which is exact modulo DIM for power-of-two DIM.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < DIM; i++) begin
            src[i] = dir ? (IDX_W'(i) - amt) : (IDX_W'(i) + amt);
            rotated[W-1-i*BYTE_W -: BYTE_W] = cells[src[i]];
        end
    end

endmodule

// File: rtl/aes_state_buf.sv
// AES state buffer: registered DIM x DIM byte matrix with row/column access,
// multi-cycle (Inv)ShiftRows and a one-deep read response register.
// Optional feature macro: AES_STATE_BUF_TRANSPOSE_EN enables single-cycle
// transpose on op 7; without it op 7 is a no-op that pulses cmd_err.
module aes_state_buf
    import aes_state_pkg::*;
#(
    parameter int unsigned DIM    = DIM_DEF,
    parameter int unsigned BYTE_W = BYTE_W_DEF
) (
    input logic            clk,
    input logic            rst,
    aes_state_buf_if.slave bus
);

    localparam int unsigned W     = DIM * BYTE_W;
    localparam int unsigned IDX_W = $clog2(DIM);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    localparam logic [IDX_W-1:0] LastRow  = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] FirstRow = IDX_W'(1);

    logic [BYTE_W-1:0] mat_q [DIM][DIM];
    logic [BYTE_W-1:0] mat_d [DIM][DIM];
    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic              dir_q, dir_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic              err_q, err_d;

    logic              accept;
    logic [W-1:0]      col_sel, row_sel;
    logic [W-1:0]      shift_row, shift_rot;

    // Outputs: a held response blocks new commands until it is consumed.
    assign bus.cmd_ready = (state_q == StIdle) & (~rsp_valid_q | bus.rsp_ready);
    assign bus.busy      = (state_q == StShift);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.cmd_err   = err_q;
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    // Gather the addressed column/row and the row currently being shifted.
    always_comb begin
        col_sel   = '0;
        row_sel   = '0;
        shift_row = '0;
        for (int i = 0; i < DIM; i++) begin
            col_sel[W-1-i*BYTE_W -: BYTE_W]   = mat_q[i][bus.cmd_idx];
            row_sel[W-1-i*BYTE_W -: BYTE_W]   = mat_q[bus.cmd_idx][i];
            shift_row[W-1-i*BYTE_W -: BYTE_W] = mat_q[row_q][i];
        end
    end

    // Single rotator shared across rows; row r rotates by r cells.
    aes_row_rot #(
        .DIM    (DIM),
        .BYTE_W (BYTE_W)
    ) u_row_rot (
        .row     (shift_row),
        .amt     (row_q),
        .dir     (dir_q),
        .rotated (shift_rot)
    );

    // Next-state logic for the matrix, FSM and response register.
    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_d[r][c] = mat_q[r][c];
            end
        end
        state_d     = state_q;
        row_d       = row_q;
        dir_d       = dir_q;
        rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
        rsp_data_d  = rsp_data_q;
        err_d       = 1'b0;

        if (state_q == StShift) begin
            for (int c = 0; c < DIM; c++) begin
                mat_d[row_q][c] = shift_rot[W-1-c*BYTE_W -: BYTE_W];
            end
            if (row_q == LastRow) begin
                state_d = StIdle;
            end else begin
                row_d = row_q + FirstRow;
            end
        end else if (accept) begin
            unique case (bus.cmd_op)
                OpWrCol: begin
                    for (int r = 0; r < DIM; r++) begin
                        mat_d[r][bus.cmd_idx] = bus.cmd_data[W-1-r*BYTE_W -: BYTE_W];
                    end
                end
                OpWrRow: begin
                    for (int c = 0; c < DIM; c++) begin
                        mat_d[bus.cmd_idx][c] = bus.cmd_data[W-1-c*BYTE_W -: BYTE_W];
                    end
                end
                OpRdCol: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = col_sel;
                end
                OpRdRow: begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = row_sel;
                end
                OpShiftRows, OpInvShiftRows: begin
                    // Row 0 never moves, so the walk starts at row 1.
                    state_d = StShift;
                    row_d   = FirstRow;
                    dir_d   = (bus.cmd_op == OpInvShiftRows);
                end
                OpClear: begin
                    for (int r = 0; r < DIM; r++) begin
                        for (int c = 0; c < DIM; c++) begin
                            mat_d[r][c] = '0;
                        end
                    end
                end
                OpTranspose: begin
`ifdef AES_STATE_BUF_TRANSPOSE_EN
                    for (int r = 0; r < DIM; r++) begin
                        for (int c = 0; c < DIM; c++) begin
                            mat_d[r][c] = mat_q[c][r];
                        end
                    end
`else
                    err_d = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // State registers; reset discards any partially shifted matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mat_q[r][c] <= '0;
                end
            end
            state_q     <= StIdle;
            row_q       <= '0;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mat_q[r][c] <= mat_d[r][c];
                end
            end
            state_q     <= state_d;
            row_q       <= row_d;
            dir_q       <= dir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

endmodule
